demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter CHANNELS, default 8, number of output channels (2..16).
REQ-003 Parameter SEL_W, default 3, select width; SHALL satisfy 2**SEL_W >= CHANNELS.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 mode  in  2  00 addressed, 01 broadcast, 10 sequential, 11 reserved (treated as 00).
REQ-007 in_valid  in  1  source has a word.
REQ-008 in_data  in  WIDTH  source word.
REQ-009 in_sel  in  SEL_W  target channel in addressed mode; ignored in other modes.
REQ-010 in_ready  out  1  block accepts word this cycle (combinational).
REQ-011 out_valid  out  CHANNELS  bit i = channel i holds a word.
REQ-012 out_data  out  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
REQ-013 out_ready  in  CHANNELS  bit i = sink i consumes word this cycle.
REQ-014 err  out  1  one-cycle pulse: word dropped for out-of-range select.
REQ-015 ptr  out  SEL_W  current sequential-mode target channel.

Function
REQ-016 Each channel SHALL have one holding register (data + valid); input accept = in_valid && in_ready; drain of i = out_valid[i] && out_ready[i].
REQ-017 Channel i is free this cycle when out_valid[i]==0 or out_ready[i]==1.
REQ-018 Addressed: in_ready = channel in_sel free; if in_sel >= CHANNELS, in_ready=1.
REQ-019 Broadcast: in_ready = all channels free; accept loads in_data into every channel.
REQ-020 Sequential: in_ready = channel ptr free; accept loads channel ptr, then ptr increments, wrapping CHANNELS-1 -> 0.
REQ-021 ptr SHALL change only on sequential-mode accept; mode changes do not alter ptr.
REQ-022 Latency: word accepted at edge k SHALL appear with out_valid set after edge k (visible cycle k+1).
REQ-023 Simultaneous drain and load of same channel: new word loaded, out_valid stays 1, no bubble.
REQ-024 Drain without load: out_valid[i] cleared and out_data slot i cleared to 0 at the same edge.
REQ-025 out_data slot i SHALL read 0 whenever out_valid[i]==0 (unselected outputs zero).
REQ-026 Addressed accept with in_sel >= CHANNELS: no channel written, err=1 for the cycle after the accepting edge, otherwise err=0.
REQ-027 A loaded word SHALL remain stable on out_data until drained, regardless of in_data, in_sel or mode changes.
REQ-028 Channels drain independently; a stalled channel SHALL NOT block accepts targeting other free channels (except broadcast).
REQ-029 No word SHALL be duplicated (except broadcast) or lost (except REQ-026).

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, all out_data=0, ptr=0, err=0, independent of clk.
REQ-031 During reset in_ready SHALL be 0; first accept possible at first rising edge after rst_n deasserts.
REQ-032 Reset mid-operation discards all held words; no partial state survives.

Verification
REQ-033 Addressed: mode=00, in_sel=5, in_data=0xA5, out_ready=0 -> next cycle out_valid=0x20, slot5=0xA5, others 0; second word to ch5 -> in_ready=0.
REQ-034 Broadcast: mode=01, out_valid[2]=1 with out_ready[2]=0 -> in_ready=0; release out_ready -> word 0x3C in all 8 slots, out_valid=0xFF.
REQ-035 Sequential wrap: mode=10, out_ready=all 1, 10 words 0..9 -> channels 0..7,0,1 in order; ptr ends at 2.
REQ-036 Pass-through: CHANNELS=6, sel=3, out_ready[3]=1, in_valid held 4 cycles -> 4 words at ch3 back-to-back, out_valid[3] continuous.
REQ-037 Range error: CHANNELS=6, mode=00, in_sel=7 -> in_ready=1, err pulses one cycle, out_valid unchanged.
REQ-038 Async reset: assert rst_n mid-clock with out_valid=0x0F, ptr=3 -> outputs 0, ptr 0 before next edge.

Source files
------------

// File: rtl/demux_stream.sv
// Stream demultiplexer: one source word steered into per-channel holding registers
// in addressed, broadcast or round-robin (sequential) fashion.
module demux_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic                      in_ready,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      err,
    output logic [SEL_W-1:0]          ptr
);

    localparam int NSEL = 1 << SEL_W;
    localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] PTR_MAX = SEL_W'(CHANNELS - 1);
    localparam logic [NSEL-1:0]  ONE_HOT0 = {{(NSEL-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_ADDR  = 2'b00,
        MODE_BCAST = 2'b01,
        MODE_SEQ   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    logic [CHANNELS-1:0]             valid_q, valid_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  data_q, data_d;
    logic [SEL_W-1:0]                ptr_q, ptr_d;
    logic                            err_q, err_d;

    logic [CHANNELS-1:0] free;
    logic [NSEL-1:0]     free_ext;
    logic [NSEL-1:0]     sel_oh;
    logic [NSEL-1:0]     ptr_oh;
    logic [CHANNELS-1:0] load_mask;
    logic                sel_oor;
    logic                ready_c;
    logic                accept;
    mode_e               mode_s;

    always_comb begin
        mode_s   = mode_e'(mode);
        free     = ~valid_q | out_ready;
        free_ext = '0;
        free_ext[CHANNELS-1:0] = free;
        sel_oh   = ONE_HOT0 << in_sel;
        ptr_oh   = ONE_HOT0 << ptr_q;
        sel_oor  = {1'b0, in_sel} >= CH_CNT;

        ready_c   = 1'b0;
        load_mask = '0;
        case (mode_s)
            MODE_BCAST: begin
                ready_c   = &free;
                load_mask = '1;
            end
            MODE_SEQ: begin
                ready_c   = free_ext[ptr_q];
                load_mask = ptr_oh[CHANNELS-1:0];
            end
            default: begin
                // Out-of-range select is swallowed: ready, but no channel bit set.
                ready_c   = sel_oor | free_ext[in_sel];
                load_mask = sel_oh[CHANNELS-1:0];
            end
        endcase

        in_ready = rst_n & ready_c;
        accept   = in_valid & in_ready;
        if (!accept) begin
            load_mask = '0;
        end

        err_d = accept && (mode_s == MODE_ADDR || mode_s == MODE_RSVD) && sel_oor;

        ptr_d = ptr_q;
        if (accept && mode_s == MODE_SEQ) begin
            ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + SEL_W'(1);
        end

        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load_mask[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
            end else if (valid_q[i] && out_ready[i]) begin
                // Empty slots read as zero on out_data.
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign ptr       = ptr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed tables on a 6-channel instance,
// hand sequences and a randomized reference model on the default 8-channel instance.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miscompares = 0;

    // 8-channel instance (defaults)
    logic [1:0]  a_mode;
    logic        a_iv;
    logic [7:0]  a_data;
    logic [2:0]  a_sel;
    logic        a_rdy;
    logic [7:0]  a_ov;
    logic [63:0] a_od;
    logic [7:0]  a_ordy;
    logic        a_err;
    logic [2:0]  a_ptr;

    // 6-channel instance
    logic [1:0]  b_mode;
    logic        b_iv;
    logic [7:0]  b_data;
    logic [2:0]  b_sel;
    logic        b_rdy;
    logic [5:0]  b_ov;
    logic [47:0] b_od;
    logic [5:0]  b_ordy;
    logic        b_err;
    logic [2:0]  b_ptr;

    demux_stream dut8 (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_valid(a_iv), .in_data(a_data),
        .in_sel(a_sel), .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od),
        .out_ready(a_ordy), .err(a_err), .ptr(a_ptr)
    );

    demux_stream #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_iv), .in_data(b_data),
        .in_sel(b_sel), .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od),
        .out_ready(b_ordy), .err(b_err), .ptr(b_ptr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        iv;
        logic [2:0]  sel;
        logic [7:0]  data;
        logic [5:0]  ordy;
        logic        exp_rdy;
        logic [5:0]  exp_ov;
        logic [47:0] exp_od;
        logic        exp_err;
        logic [2:0]  exp_ptr;
    } vec_t;

    vec_t tbl[15];

    // reference model state for the 8-channel instance
    logic [7:0] m_v;
    logic [7:0] m_d[8];
    int         m_ptr;

    initial begin
        logic [63:0] e_od;
        int          tgt[$];
        int          em;
        logic        e_rdy;

        tbl[0]  = '{2'b00, 1'b1, 3'd3, 8'h11, 6'h00, 1'b1, 6'h08, 48'h000011000000, 1'b0, 3'd0};
        tbl[1]  = '{2'b00, 1'b1, 3'd3, 8'h22, 6'h00, 1'b0, 6'h08, 48'h000011000000, 1'b0, 3'd0};
        tbl[2]  = '{2'b00, 1'b1, 3'd3, 8'h22, 6'h08, 1'b1, 6'h08, 48'h000022000000, 1'b0, 3'd0};
        tbl[3]  = '{2'b00, 1'b1, 3'd3, 8'h33, 6'h08, 1'b1, 6'h08, 48'h000033000000, 1'b0, 3'd0};
        tbl[4]  = '{2'b00, 1'b1, 3'd3, 8'h44, 6'h08, 1'b1, 6'h08, 48'h000044000000, 1'b0, 3'd0};
        tbl[5]  = '{2'b00, 1'b1, 3'd3, 8'h55, 6'h00, 1'b0, 6'h08, 48'h000044000000, 1'b0, 3'd0};
        tbl[6]  = '{2'b00, 1'b1, 3'd7, 8'h99, 6'h00, 1'b1, 6'h08, 48'h000044000000, 1'b1, 3'd0};
        tbl[7]  = '{2'b00, 1'b0, 3'd0, 8'h00, 6'h00, 1'b1, 6'h08, 48'h000044000000, 1'b0, 3'd0};
        tbl[8]  = '{2'b00, 1'b1, 3'd6, 8'h77, 6'h00, 1'b1, 6'h08, 48'h000044000000, 1'b1, 3'd0};
        tbl[9]  = '{2'b11, 1'b1, 3'd0, 8'h5A, 6'h00, 1'b1, 6'h09, 48'h00004400005A, 1'b0, 3'd0};
        tbl[10] = '{2'b01, 1'b1, 3'd7, 8'hC3, 6'h00, 1'b0, 6'h09, 48'h00004400005A, 1'b0, 3'd0};
        tbl[11] = '{2'b01, 1'b1, 3'd7, 8'hC3, 6'h09, 1'b1, 6'h3F, 48'hC3C3C3C3C3C3, 1'b0, 3'd0};
        tbl[12] = '{2'b10, 1'b1, 3'd5, 8'h01, 6'h3F, 1'b1, 6'h01, 48'h000000000001, 1'b0, 3'd1};
        tbl[13] = '{2'b10, 1'b0, 3'd0, 8'h00, 6'h00, 1'b1, 6'h01, 48'h000000000001, 1'b0, 3'd1};
        tbl[14] = '{2'b00, 1'b0, 3'd0, 8'h00, 6'h01, 1'b1, 6'h00, 48'h000000000000, 1'b0, 3'd1};

        a_mode = 2'b00; a_iv = 1'b1; a_data = 8'hFF; a_sel = 3'd0; a_ordy = 8'h00;
        b_mode = 2'b00; b_iv = 1'b1; b_data = 8'hFF; b_sel = 3'd7; b_ordy = 6'h00;

        // reset state and in_ready held low during reset
        #2;
        chk("rst_ready8", 64'(a_rdy), 64'd0);
        chk("rst_ready6", 64'(b_rdy), 64'd0);
        chk("rst_ov8", 64'(a_ov), 64'd0);
        chk("rst_od8", a_od, 64'd0);
        chk("rst_ptr8", 64'(a_ptr), 64'd0);
        chk("rst_err6", 64'(b_err), 64'd0);
        a_iv = 1'b0; b_iv = 1'b0;
        #5 rst_n = 1'b1;
        tick();

        // directed table on the 6-channel instance
        for (int i = 0; i < 15; i++) begin
            b_mode = tbl[i].mode; b_iv = tbl[i].iv; b_sel = tbl[i].sel;
            b_data = tbl[i].data; b_ordy = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(b_rdy), 64'(tbl[i].exp_rdy));
            tick();
            chk($sformatf("tbl%0d_ov", i), 64'(b_ov), 64'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_od", i), 64'(b_od), 64'(tbl[i].exp_od));
            chk($sformatf("tbl%0d_err", i), 64'(b_err), 64'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_ptr", i), 64'(b_ptr), 64'(tbl[i].exp_ptr));
        end
        b_iv = 1'b0; b_ordy = 6'h00;

        // addressed word to ch5, then a second word must stall
        a_mode = 2'b00; a_sel = 3'd5; a_data = 8'hA5; a_ordy = 8'h00; a_iv = 1'b1;
        tick();
        chk("addr_ov", 64'(a_ov), 64'h20);
        chk("addr_od", a_od, 64'hA5 << 40);
        a_data = 8'h5A;
        #1;
        chk("addr_full_ready", 64'(a_rdy), 64'd0);
        a_iv = 1'b0; a_ordy = 8'hFF;
        tick();
        chk("addr_drain_ov", 64'(a_ov), 64'h00);

        // broadcast blocked by one stalled channel
        a_ordy = 8'h00; a_sel = 3'd2; a_data = 8'h77; a_iv = 1'b1;
        tick();
        a_mode = 2'b01; a_data = 8'h3C;
        #1;
        chk("bc_blocked_ready", 64'(a_rdy), 64'd0);
        tick();
        chk("bc_blocked_ov", 64'(a_ov), 64'h04);
        a_ordy = 8'h04;
        #1;
        chk("bc_ready", 64'(a_rdy), 64'd1);
        tick();
        chk("bc_ov", 64'(a_ov), 64'hFF);
        chk("bc_od", a_od, {8{8'h3C}});
        a_iv = 1'b0; a_ordy = 8'hFF;
        tick();

        // sequential wrap, 10 words
        a_mode = 2'b10; a_iv = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a_data = 8'(k);
            #1;
            chk($sformatf("seq%0d_ready", k), 64'(a_rdy), 64'd1);
            tick();
            chk($sformatf("seq%0d_ov", k), 64'(a_ov), 64'd1 << (k % 8));
            chk($sformatf("seq%0d_od", k), a_od, 64'(k) << ((k % 8) * 8));
        end
        chk("seq_ptr_end", 64'(a_ptr), 64'd2);

        // build out_valid=0x0F, ptr=3, then reset mid-cycle
        a_iv = 1'b0;
        tick();
        a_ordy = 8'h00; a_iv = 1'b1; a_data = 8'hEE;
        tick();
        a_mode = 2'b00;
        a_sel = 3'd0; tick();
        a_sel = 3'd1; tick();
        a_sel = 3'd3; tick();
        a_iv = 1'b0; a_sel = 3'd4;
        chk("pre_rst_ov", 64'(a_ov), 64'h0F);
        chk("pre_rst_ptr", 64'(a_ptr), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 64'(a_ov), 64'd0);
        chk("arst_od", a_od, 64'd0);
        chk("arst_ptr", 64'(a_ptr), 64'd0);
        chk("arst_err", 64'(a_err), 64'd0);
        chk("arst_ready", 64'(a_rdy), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // randomized traffic against the reference model
        m_v = '0;
        m_ptr = 0;
        for (int i = 0; i < 8; i++) m_d[i] = '0;
        for (int c = 0; c < 400; c++) begin
            a_mode = 2'($urandom_range(0, 3));
            a_iv   = ($urandom_range(0, 3) != 0);
            a_sel  = 3'($urandom_range(0, 7));
            a_data = 8'($urandom);
            a_ordy = 8'($urandom) & 8'($urandom | 32'h55);
            em = (a_mode == 2'b11) ? 0 : int'(a_mode);
            tgt.delete();
            if (em == 1) begin
                for (int i = 0; i < 8; i++) tgt.push_back(i);
            end else if (em == 2) begin
                tgt.push_back(m_ptr);
            end else begin
                tgt.push_back(int'(a_sel));
            end
            e_rdy = 1'b1;
            foreach (tgt[j]) if (m_v[tgt[j]] && !a_ordy[tgt[j]]) e_rdy = 1'b0;
            #1;
            chk($sformatf("rnd%0d_ready", c), 64'(a_rdy), 64'(e_rdy));
            tick();
            for (int i = 0; i < 8; i++) begin
                if (m_v[i] && a_ordy[i]) begin
                    m_v[i] = 1'b0;
                    m_d[i] = '0;
                end
            end
            if (a_iv && e_rdy) begin
                foreach (tgt[j]) begin
                    m_v[tgt[j]] = 1'b1;
                    m_d[tgt[j]] = a_data;
                end
                if (em == 2) m_ptr = (m_ptr + 1) % 8;
            end
            e_od = '0;
            for (int i = 0; i < 8; i++) e_od[i*8 +: 8] = m_d[i];
            chk($sformatf("rnd%0d_ov", c), 64'(a_ov), 64'(m_v));
            chk($sformatf("rnd%0d_od", c), a_od, e_od);
            chk($sformatf("rnd%0d_ptr", c), 64'(a_ptr), 64'(m_ptr));
            chk($sformatf("rnd%0d_err", c), 64'(a_err), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
